// File: rtl/seq_gen_pkg.sv
// Shared definitions for the single-clock pattern generator: playback states,
// register map and the offset of the pattern memory window.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int ADDR_VERSION = 0;
    localparam int ADDR_START   = 1;
    localparam int ADDR_EN_EXT  = 2;
    localparam int ADDR_SIZE_LO = 3;
    localparam int ADDR_SIZE_HI = 4;
    localparam int ADDR_CLK_DIV = 5;
    localparam int ADDR_WAIT_LO = 6;
    localparam int ADDR_WAIT_HI = 7;
    localparam int ADDR_REPEAT  = 8;
    localparam int MEM_OFFSET   = 16;

endpackage

// File: rtl/seq_gen_mem.sv
// Same-clock dual-port pattern RAM: byte-wide bus read/write port and a
// word-wide read-only playback port whose output register clears when idle.
module seq_gen_mem
    import seq_gen_pkg::*;
#(
    parameter int MEM_BYTES = 8192,
    parameter int OUT_BITS  = 8,
    localparam int BPW      = OUT_BITS / 8,
    localparam int DEPTH    = MEM_BYTES / BPW,
    localparam int AW       = $clog2(DEPTH),
    localparam int BA       = $clog2(MEM_BYTES),
    localparam int LW       = (BPW > 1) ? $clog2(BPW) : 1
) (
    input  logic                i_clk,
    input  logic [BA-1:0]       i_bus_addr,
    input  logic                i_bus_wr,
    input  logic [7:0]          i_bus_wdata,
    output logic [7:0]          o_bus_rdata,
    input  logic                i_play_en,
    input  logic [AW-1:0]       i_play_addr,
    output logic [OUT_BITS-1:0] o_play_data
);

    logic [OUT_BITS-1:0] r_mem [DEPTH];
    logic [OUT_BITS-1:0] r_bus_word;
    logic [OUT_BITS-1:0] r_play;
    logic [LW-1:0]       r_lane;
    logic [AW-1:0]       w_word;
    logic [LW-1:0]       w_lane;

    // Little-endian: byte lane l of a word holds byte address word*BPW + l.
    assign w_word = AW'(i_bus_addr / BA'(BPW));
    assign w_lane = LW'(i_bus_addr % BA'(BPW));

    // Bus port: byte-lane write, full-word read with registered lane select.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < BPW; l++) begin
            if (i_bus_wr && (w_lane == LW'(l))) begin
                r_mem[w_word][l*8 +: 8] <= i_bus_wdata;
            end
        end
        r_bus_word <= r_mem[w_word];
        r_lane     <= w_lane;
    end

    // Playback port: read-before-write, output forced to zero when not playing.
    always_ff @(posedge i_clk) begin
        if (i_play_en) begin
            r_play <= r_mem[i_play_addr];
        end else begin
            r_play <= '0;
        end
    end

    assign o_bus_rdata = 8'(r_bus_word >> {r_lane, 3'b000});
    assign o_play_data = r_play;

endmodule

// File: rtl/seq_gen_sc.sv
// Pattern generator top: register file, start-event detection and the
// IDLE/RUN/WAIT playback sequencer driving the pattern RAM.
module seq_gen_sc
    import seq_gen_pkg::*;
#(
    parameter int ABUSWIDTH = 16,
    parameter int MEM_BYTES = 8 * 1024,
    parameter int OUT_BITS  = 8,
    parameter int VERSION   = 1
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic                 SEQ_EXT_START,
    output logic [OUT_BITS-1:0]  SEQ_OUT,
    output logic                 SEQ_DONE
);

    localparam int DEPTH = MEM_BYTES * 8 / OUT_BITS;
    localparam int AW    = $clog2(DEPTH);
    localparam int BA    = $clog2(MEM_BYTES);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_step, w_step_nxt;
    logic [7:0]  r_div, w_div_nxt;
    logic [7:0]  r_rep, w_rep_nxt;
    logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
    logic        r_done_pre, w_done_pre_nxt, r_done;
    logic        r_en_ext, r_ext_d, r_ext_rise;
    logic [15:0] r_size, r_wait, r_run_size, r_run_wait;
    logic [7:0]  r_clk_div, r_repeat, r_run_div, r_run_rep;
    logic [7:0]  r_rdata, w_reg_rdata, w_mem_byte;
    logic        r_rd_mem;
    logic [31:0] w_addr32;
    logic [15:0] w_eff_size;
    logic        w_srst, w_in_mem, w_start, w_last_step;

    assign w_addr32    = 32'(BUS_ADD);
    assign w_srst      = BUS_RST | (BUS_WR && (w_addr32 == ADDR_VERSION));
    assign w_in_mem    = (w_addr32 >= MEM_OFFSET) && (w_addr32 < MEM_OFFSET + MEM_BYTES);
    assign w_eff_size  = (32'(r_size) > DEPTH) ? 16'(DEPTH) : r_size;
    assign w_start     = ((BUS_WR && (w_addr32 == ADDR_START)) || (r_en_ext && r_ext_rise))
                         && (r_state == IDLE) && (w_eff_size != 16'd0);
    assign w_last_step = (r_step == r_run_size - 16'd1);

    // Configuration registers.
    always_ff @(posedge BUS_CLK) begin
        if (w_srst) begin
            r_en_ext  <= 1'b0;
            r_size    <= 16'd0;
            r_clk_div <= 8'd0;
            r_wait    <= 16'd0;
            r_repeat  <= 8'd1;
        end else if (BUS_WR) begin
            case (w_addr32)
                ADDR_EN_EXT:  r_en_ext      <= BUS_DATA_IN[0];
                ADDR_SIZE_LO: r_size[7:0]   <= BUS_DATA_IN;
                ADDR_SIZE_HI: r_size[15:8]  <= BUS_DATA_IN;
                ADDR_CLK_DIV: r_clk_div     <= BUS_DATA_IN;
                ADDR_WAIT_LO: r_wait[7:0]   <= BUS_DATA_IN;
                ADDR_WAIT_HI: r_wait[15:8]  <= BUS_DATA_IN;
                ADDR_REPEAT:  r_repeat      <= BUS_DATA_IN;
                default:      r_repeat      <= r_repeat;
            endcase
        end
    end

    // External start: registered rising-edge detector (one cycle of latency).
    always_ff @(posedge BUS_CLK) begin
        if (w_srst) begin
            r_ext_d    <= 1'b0;
            r_ext_rise <= 1'b0;
        end else begin
            r_ext_d    <= SEQ_EXT_START;
            r_ext_rise <= SEQ_EXT_START & ~r_ext_d;
        end
    end

    // Run parameters are frozen at start so mid-run writes only affect the next run.
    always_ff @(posedge BUS_CLK) begin
        if (w_srst) begin
            r_run_size <= 16'd0;
            r_run_div  <= 8'd0;
            r_run_wait <= 16'd0;
            r_run_rep  <= 8'd1;
        end else if (w_start) begin
            r_run_size <= w_eff_size;
            r_run_div  <= r_clk_div;
            r_run_wait <= r_wait;
            r_run_rep  <= r_repeat;
        end
    end

    // Sequencer state and counters; SEQ_DONE is delayed to line up with SEQ_OUT.
    always_ff @(posedge BUS_CLK) begin
        if (w_srst) begin
            r_state    <= IDLE;
            r_step     <= 16'd0;
            r_div      <= 8'd0;
            r_rep      <= 8'd0;
            r_wait_cnt <= 16'd0;
            r_done_pre <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_step     <= w_step_nxt;
            r_div      <= w_div_nxt;
            r_rep      <= w_rep_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_done_pre <= w_done_pre_nxt;
            r_done     <= r_done_pre;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_div_nxt      = r_div;
        w_rep_nxt      = r_rep;
        w_wait_cnt_nxt = r_wait_cnt;
        w_done_pre_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = RUN;
                    w_step_nxt  = 16'd0;
                    w_div_nxt   = 8'd0;
                    w_rep_nxt   = 8'd1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (r_div != r_run_div) begin
                    w_div_nxt = r_div + 8'd1;
                end else if (!w_last_step) begin
                    w_div_nxt  = 8'd0;
                    w_step_nxt = r_step + 16'd1;
                end else if ((r_run_rep != 8'd0) && (r_rep == r_run_rep)) begin
                    w_div_nxt      = 8'd0;
                    w_step_nxt     = 16'd0;
                    w_state_nxt    = IDLE;
                    w_done_pre_nxt = 1'b1;
                end else begin
                    w_div_nxt      = 8'd0;
                    w_step_nxt     = 16'd0;
                    w_wait_cnt_nxt = 16'd0;
                    w_rep_nxt      = (r_rep == 8'd255) ? 8'd255 : r_rep + 8'd1;
                    w_state_nxt    = (r_run_wait == 16'd0) ? RUN : WAIT;
                end
            end
            WAIT: begin
                if (r_wait_cnt == r_run_wait - 16'd1) begin
                    w_state_nxt = RUN;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Register read mux.
    always_comb begin
        w_reg_rdata = 8'd0;
        case (w_addr32)
            ADDR_VERSION: w_reg_rdata = 8'(VERSION);
            ADDR_START:   w_reg_rdata = {7'd0, (r_state == IDLE)};
            ADDR_EN_EXT:  w_reg_rdata = {7'd0, r_en_ext};
            ADDR_SIZE_LO: w_reg_rdata = r_size[7:0];
            ADDR_SIZE_HI: w_reg_rdata = r_size[15:8];
            ADDR_CLK_DIV: w_reg_rdata = r_clk_div;
            ADDR_WAIT_LO: w_reg_rdata = r_wait[7:0];
            ADDR_WAIT_HI: w_reg_rdata = r_wait[15:8];
            ADDR_REPEAT:  w_reg_rdata = r_repeat;
            default:      w_reg_rdata = 8'd0;
        endcase
    end

    // Read data capture; memory bytes come from the RAM's own output register.
    always_ff @(posedge BUS_CLK) begin
        if (w_srst) begin
            r_rdata  <= 8'd0;
            r_rd_mem <= 1'b0;
        end else begin
            r_rdata  <= BUS_RD ? w_reg_rdata : 8'd0;
            r_rd_mem <= BUS_RD & w_in_mem;
        end
    end

    seq_gen_mem #(
        .MEM_BYTES (MEM_BYTES),
        .OUT_BITS  (OUT_BITS)
    ) u_mem (
        .i_clk       (BUS_CLK),
        .i_bus_addr  (BA'(w_addr32 - MEM_OFFSET)),
        .i_bus_wr    (BUS_WR & w_in_mem),
        .i_bus_wdata (BUS_DATA_IN),
        .o_bus_rdata (w_mem_byte),
        .i_play_en   ((r_state == RUN) & ~w_srst),
        .i_play_addr (AW'(r_step)),
        .o_play_data (SEQ_OUT)
    );

    assign BUS_DATA_OUT = r_rd_mem ? w_mem_byte : r_rdata;
    assign SEQ_DONE     = r_done;

endmodule

// File: tb/tb_seq_gen_sc.sv
// Self-checking bench for seq_gen_sc: directed scenarios plus randomized runs
// compared cycle by cycle against a queue-based playback model.
module tb_seq_gen_sc;

    localparam int MEM_BYTES = 8192;
    localparam int DEPTH8    = 8192;

    logic        clk = 1'b0;
    logic        rst, rd, wr, ext;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata8, rdata16, out8;
    logic [15:0] out16;
    logic        done8, done16;

    always #5 clk = ~clk;

    seq_gen_sc #(.ABUSWIDTH(16), .MEM_BYTES(MEM_BYTES), .OUT_BITS(8), .VERSION(1)) dut8 (
        .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(addr), .BUS_DATA_IN(wdata),
        .BUS_DATA_OUT(rdata8), .BUS_RD(rd), .BUS_WR(wr), .SEQ_EXT_START(ext),
        .SEQ_OUT(out8), .SEQ_DONE(done8));

    seq_gen_sc #(.ABUSWIDTH(16), .MEM_BYTES(MEM_BYTES), .OUT_BITS(16), .VERSION(1)) dut16 (
        .BUS_CLK(clk), .BUS_RST(rst), .BUS_ADD(addr), .BUS_DATA_IN(wdata),
        .BUS_DATA_OUT(rdata16), .BUS_RD(rd), .BUS_WR(wr), .SEQ_EXT_START(ext),
        .SEQ_OUT(out16), .SEQ_DONE(done16));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem_model [MEM_BYTES];
    int         m_size, m_div, m_wait, m_rep;
    logic [7:0] exp_out  [$];
    logic       exp_done [$];
    logic [7:0] r8, r16;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d8, output logic [7:0] d16);
        @(posedge clk);
        #1;
        addr = a; rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        d8 = rdata8; d16 = rdata16;
    endtask

    task automatic mem_write(input int i, input logic [7:0] b);
        bus_write(16'(16 + i), b);
        mem_model[i] = b;
    endtask

    task automatic config_run(input int size, input int div, input int wt, input int rep);
        bus_write(16'd3, 8'(size));
        bus_write(16'd4, 8'(size >> 8));
        bus_write(16'd5, 8'(div));
        bus_write(16'd6, 8'(wt));
        bus_write(16'd7, 8'(wt >> 8));
        bus_write(16'd8, 8'(rep));
        m_size = size; m_div = div; m_wait = wt; m_rep = rep;
    endtask

    task automatic model_defaults();
        m_size = 0; m_div = 0; m_wait = 0; m_rep = 1;
    endtask

    // Expected per-cycle SEQ_OUT/SEQ_DONE from the first playback cycle onward.
    task automatic build_exp(input int reps, input bit finite);
        int eff;
        eff = (m_size < DEPTH8) ? m_size : DEPTH8;
        for (int r = 0; r < reps; r++) begin
            for (int w = 0; w < eff; w++)
                for (int d = 0; d <= m_div; d++) begin
                    exp_out.push_back(mem_model[w]);
                    exp_done.push_back(1'b0);
                end
            if (r != reps - 1 || !finite)
                for (int g = 0; g < m_wait; g++) begin
                    exp_out.push_back(8'h00);
                    exp_done.push_back(1'b0);
                end
        end
        if (finite) begin
            exp_out.push_back(8'h00); exp_done.push_back(1'b1);
            exp_out.push_back(8'h00); exp_done.push_back(1'b0);
            exp_out.push_back(8'h00); exp_done.push_back(1'b0);
        end
    endtask

    task automatic play_check(input string tag);
        while (exp_out.size() != 0) begin
            step();
            check_eq({tag, "_out"}, 32'(out8), 32'(exp_out.pop_front()));
            check_eq({tag, "_done"}, 32'(done8), 32'(exp_done.pop_front()));
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step();
            check_eq({tag, "_out"}, 32'(out8), 32'd0);
            check_eq({tag, "_done"}, 32'(done8), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; ext = 1'b0; addr = 16'd0; wdata = 8'd0;
        model_defaults();
        repeat (3) step();
        rst = 1'b0;
        check_eq("rst_out8", 32'(out8), 32'd0);
        check_eq("rst_out16", 32'(out16), 32'd0);
        check_eq("rst_done", 32'(done8), 32'd0);
        check_eq("rst_rdata", 32'(rdata8), 32'd0);
        bus_read(16'd0, r8, r16);  check_eq("version", 32'(r8), 32'd1);
        bus_read(16'd1, r8, r16);  check_eq("ready_rst", 32'(r8), 32'd1);
        bus_read(16'd8, r8, r16);  check_eq("repeat_dflt", 32'(r8), 32'd1);
        bus_read(16'd3, r8, r16);  check_eq("size_dflt", 32'(r8), 32'd0);
        bus_read(16'd9, r8, r16);  check_eq("unmapped9", 32'(r8), 32'd0);

        for (int i = 0; i < MEM_BYTES; i++) mem_write(i, 8'($urandom));

        // Single pass, no divider.
        mem_write(0, 8'h11); mem_write(1, 8'h22); mem_write(2, 8'h33);
        config_run(3, 0, 0, 1);
        bus_write(16'd1, 8'd0);
        build_exp(1, 1'b1);
        play_check("t1");
        bus_read(16'd1, r8, r16);  check_eq("t1_ready", 32'(r8), 32'd1);

        // Divider, two repeats, idle gap.
        config_run(3, 2, 4, 2);
        bus_write(16'd1, 8'd0);
        build_exp(2, 1'b1);
        play_check("t2");

        // Zero size ignored; oversize clipped to memory depth.
        config_run(0, 0, 0, 1);
        bus_write(16'd1, 8'd0);
        idle_check("t3_zero", 6);
        bus_read(16'd1, r8, r16);  check_eq("t3_ready", 32'(r8), 32'd1);
        config_run(16'hFFFF, 0, 0, 1);
        bus_write(16'd1, 8'd0);
        build_exp(1, 1'b1);
        play_check("t3_full");

        // External start: edge during a run ignored, edge in IDLE starts.
        bus_write(16'd2, 8'd1);
        config_run(3, 3, 0, 1);
        bus_write(16'd1, 8'd0);
        ext = 1'b1;
        build_exp(1, 1'b1);
        play_check("t4_bus");
        ext = 1'b0;
        step(); step();
        ext = 1'b1;
        step(); step();
        build_exp(1, 1'b1);
        play_check("t4_ext");
        ext = 1'b0;
        bus_write(16'd2, 8'd0);
        ext = 1'b1;
        idle_check("t4_dis", 8);
        ext = 1'b0;

        // Infinite loop, then soft reset mid-word.
        config_run(3, 2, 0, 0);
        bus_write(16'd1, 8'd0);
        build_exp(3, 1'b0);
        play_check("t5_loop");
        exp_out.delete(); exp_done.delete();
        step();
        bus_write(16'd0, 8'd0);
        model_defaults();
        check_eq("t5_srst_out", 32'(out8), 32'd0);
        bus_read(16'd1, r8, r16);  check_eq("t5_ready", 32'(r8), 32'd1);
        bus_read(16'd8, r8, r16);  check_eq("t5_repeat", 32'(r8), 32'd1);
        for (int k = 0; k < 6; k++) begin
            int a;
            a = (k < 3) ? k : int'($urandom_range(0, MEM_BYTES - 1));
            bus_read(16'(16 + a), r8, r16);
            check_eq("t5_mem", 32'(r8), 32'(mem_model[a]));
        end

        // 16-bit little-endian word, busy READY, version, unmapped tail.
        mem_write(0, 8'h34); mem_write(1, 8'h12);
        config_run(1, 0, 0, 1);
        bus_write(16'd1, 8'd0);
        step();
        check_eq("t6_word16", 32'(out16), 32'h1234);
        check_eq("t6_word8", 32'(out8), 32'h34);
        step();
        check_eq("t6_idle16", 32'(out16), 32'd0);
        check_eq("t6_done16", 32'(done16), 32'd1);
        config_run(100, 0, 0, 1);
        bus_write(16'd1, 8'd0);
        bus_read(16'd1, r8, r16);
        check_eq("t6_busy8", 32'(r8), 32'd0);
        check_eq("t6_busy16", 32'(r16), 32'd0);
        bus_read(16'd0, r8, r16);  check_eq("t6_version", 32'(r8), 32'd1);
        bus_write(16'd0, 8'd0);
        model_defaults();
        bus_read(16'(16 + MEM_BYTES), r8, r16);  check_eq("t6_unmapped", 32'(r8), 32'd0);

        // Randomized runs.
        for (int n = 0; n < 8; n++) begin
            for (int j = 0; j < 4; j++) mem_write(int'($urandom_range(0, 31)), 8'($urandom));
            config_run(int'($urandom_range(1, 24)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 5)), int'($urandom_range(1, 3)));
            bus_write(16'd1, 8'd0);
            build_exp(m_rep, 1'b1);
            play_check("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_gen_sc.md
Name: seq_gen_sc

Overview:
Single-clock pattern generator: the transmit-side counterpart of the sequence recorder. Software loads an OUT_BITS-wide pattern into internal memory over the IP-side bus (behind bus_to_ip), then starts playback by register write or external start edge. Words are driven on SEQ_OUT, one step every CLK_DIV+1 cycles, with optional repeats separated by an idle gap. Playback runs on BUS_CLK, so there is no clock-domain crossing.

Parameters:
ABUSWIDTH, 16, IP address width
MEM_BYTES, 8*1024, pattern memory size in bytes (power of 2)
OUT_BITS, 8, output width; must be 8, 16 or 32
VERSION, 1, value read at address 0

Ports:
BUS_CLK  in  1  single clock for bus and playback
BUS_RST  in  1  synchronous active-high reset
BUS_ADD  in  ABUSWIDTH  IP-relative address
BUS_DATA_IN  in  8  write data
BUS_DATA_OUT  out  8  read data, registered
BUS_RD  in  1  read strobe
BUS_WR  in  1  write strobe
SEQ_EXT_START  in  1  external start; rising edge is the event
SEQ_OUT  out  OUT_BITS  pattern output, registered
SEQ_DONE  out  1  one-cycle pulse at the end of the final repeat

Behaviour:
- Reset (BUS_RST, or a write to address 0): all outputs 0. State IDLE. Registers take their defaults. Memory is not cleared. A soft reset mid-run returns to IDLE, and SEQ_OUT is 0 on the next cycle.
- Register map:
  - 0: read VERSION; write = soft reset.
  - 1: write = start; read bit0 = READY (state IDLE).
  - 2: bit0 EN_EXT_START, default 0.
  - 3/4: SIZE[15:0] in words, LSB at 3, default 0.
  - 5: CLK_DIV, default 0.
  - 6/7: WAIT[15:0], default 0.
  - 8: REPEAT, default 1; 0 means infinite.
  - 9–15: read 0.
  - 16 up to 16+MEM_BYTES-1: memory bytes.
- Words are little-endian: word i occupies bytes i*OUT_BITS/8 and upward.
- BUS_DATA_OUT is valid the cycle after BUS_RD. It is 0 for unmapped addresses.
- Depth is MEM_BYTES*8/OUT_BITS words. Effective size is min(SIZE, depth).
- Start event: a bus start write, or (EN_EXT_START and a rising edge of SEQ_EXT_START). The edge detector adds one cycle. Start events are ignored unless the state is IDLE and effective size > 0. Simultaneous bus and external starts count as one start.
- State machine:
  - IDLE: on a start event, go to RUN with step=0, div=0, rep=1.
  - RUN: issue the read address for step. When div reaches CLK_DIV, clear div and advance step.
  - After the last step: if REPEAT≠0 and rep==REPEAT, go to IDLE and pulse SEQ_DONE on the same cycle SEQ_OUT returns to 0.
  - Otherwise increment rep (saturating at 255 in infinite mode) and go to WAIT, or directly back to RUN at step 0 if WAIT==0.
  - WAIT: count WAIT cycles, then return to RUN at step 0.
- Timing: start write at cycle T → RUN at T+1 → SEQ_OUT=word0 at T+2. Each word is held exactly CLK_DIV+1 cycles. SEQ_OUT is 0 during IDLE and WAIT, lagging the state by one cycle. WAIT=0 gives back-to-back repeats with no gap.
- Register changes during a run:
  - SIZE, CLK_DIV and WAIT are sampled at start. Changes during a run take effect on the next start.
  - REPEAT is also sampled at start.
  - Memory writes during a run are allowed; a word shows its new value if written before it is read.
- Memory has 1-cycle read latency on the playback port. A bus write and a playback read of the same word in the same cycle return the old data.

Decomposition:
- Package seq_gen_pkg holds:
  - state enum: IDLE, RUN, WAIT;
  - register address constants;
  - the MEM_OFFSET=16 constant.
- One natural sub-module: seq_gen_mem. It is a same-clock dual-port RAM with an 8-bit bus read/write port and an OUT_BITS-wide read-only playback port, mapped to block RAM.

Test Plan:
1. Load bytes 0x11,0x22,0x33; SIZE=3, CLK_DIV=0, REPEAT=1; start at cycle T → SEQ_OUT=0x11,0x22,0x33 at T+2..T+4, then 0 at T+5 with SEQ_DONE=1, and READY reads 1.
2. Same data with CLK_DIV=2, REPEAT=2, WAIT=4 → each word held 3 cycles, then 4 cycles of 0, then the pattern again; exactly one SEQ_DONE, at the end of the second repeat.
3. SIZE=0 with a start write → no SEQ_OUT activity, READY stays 1, no SEQ_DONE. SIZE=0xFFFF with MEM_BYTES=8192 → 8192 words played, then done.
4. EN_EXT_START=1; hold SEQ_EXT_START high for 10 cycles during a run, then a new rising edge in IDLE → only the IDLE edge starts playback, 3 cycles after the edge. With EN_EXT_START=0 there is no start.
5. REPEAT=0 with WAIT=0 → continuous loop with no gap; a soft reset mid-word gives SEQ_OUT=0 the next cycle and READY=1; memory contents survive, checked by readback.
6. OUT_BITS=16, bytes 0x34,0x12 → SEQ_OUT=0x1234. A bus read of address 1 while busy → 0x00. A bus read of address 0 → VERSION, one cycle after BUS_RD.
